rx_rd_req_arbiter: RTL and testbench
====================================

Name: rx_rd_req_arbiter

Overview:
- Arbitrates between AXI read transfers and CSR memory-status-register reads for the single receive datapath (read engine, DQ FIFO, AXI read-data packer).
- Grants one requester at a time and drives start_read with axi_trigger/csr_trigger.
- Tracks completion, or abort on DQS timeout, illegal instruction or watchdog expiry.
- Sequences the mandatory DQ FIFO flush before the next grant.

Parameters:
STARVE_LIMIT, 4, consecutive AXI grants allowed while csr_rd_req is pending before the CSR requester is forced to win (1..2^STARVE_CNT_W-1)
STARVE_CNT_W, 3, width of the starvation counter
WDOG_W, 10, width of the transfer/flush watchdog counter; expiry at 2^WDOG_W-1 cycles

Ports:
mem_clk  in  1  clock
reset_n  in  1  synchronous active-low reset
axi_rd_req  in  1  AXI read request; level, held until axi_rd_ack
axi_rd_ack  out  1  one-cycle grant pulse to AXI requester
csr_rd_req  in  1  CSR status-read request; level, held until csr_rd_ack
csr_rd_ack  out  1  one-cycle grant pulse to CSR requester
start_read  out  1  level; high for the whole granted transfer
axi_trigger  out  1  level; transfer owner is AXI (valid while start_read)
csr_trigger  out  1  level; transfer owner is CSR (valid while start_read)
rd_done  in  1  pulse; AXI transfer (including continuous reads) complete
csr_read_end  in  1  pulse; CSR status read complete
dqs_timeout  in  1  pulse; DQS non-toggle abort
mem_illegal_instrn_err  in  1  level; illegal instruction
rcv_dq_fifo_flush_en  out  1  one-cycle flush request to the read engine
rcv_dq_fifo_flush_done  in  1  pulse; flush finished
busy  out  1  high in every state except IDLE
arb_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- One clock, mem_clk. Reset is synchronous, active-low on reset_n.
- All outputs are registered. Reset values: all outputs 0, FSM=IDLE, starve_cnt=0, wdog=0.
- Reset mid-operation returns to IDLE immediately. No flush is issued and no ack is generated.
- FSM states: IDLE, XFER, FLUSH.
- IDLE:
  - No grant while mem_illegal_instrn_err=1.
  - Otherwise, if either request is high, select a winner:
    - CSR wins if csr_rd_req & (!axi_rd_req | starve_cnt==STARVE_LIMIT).
    - Otherwise AXI wins.
  - Grant cycle T: request sampled.
  - At T+1: the ack pulse is high for one cycle. start_read=1, and the owner trigger is 1 (the other trigger stays 0). FSM=XFER.
  - Requester must drop its request within one cycle of the ack. No second grant is possible before FLUSH completes.
- starve_cnt:
  - Increments (saturating) on an AXI grant while csr_rd_req=1.
  - Clears on a CSR grant, or on any cycle with csr_rd_req=0.
- XFER:
  - wdog increments every cycle; it clears on entry to XFER and on entry to FLUSH.
  - Exit to FLUSH on the first of:
    - The owner's end event: rd_done for AXI, csr_read_end for CSR. The non-owner end event is ignored.
    - dqs_timeout.
    - mem_illegal_instrn_err.
    - wdog==2^WDOG_W-1, which also pulses arb_err.
  - Simultaneous events take a single transition. arb_err pulses only if the watchdog is the sole cause.
  - On the exit cycle +1: start_read=0, both triggers=0, and rcv_dq_fifo_flush_en is pulsed for one cycle.
- FLUSH:
  - Wait for rcv_dq_fifo_flush_done, then go to IDLE on the next cycle.
  - flush_done arriving in the same cycle as flush_en is accepted.
  - Watchdog expiry in FLUSH goes to IDLE with an arb_err pulse.
  - Stray flush_done in IDLE or XFER is ignored.
- Minimum turnaround, end event to next ack: 3 cycles.
- busy=1 from the ack cycle until the cycle after IDLE is re-entered.

Test Plan:
- AXI only: axi_rd_req=1 at cycle 0 -> axi_rd_ack pulse at cycle 1 with start_read=1, axi_trigger=1. rd_done at cycle 20 -> start_read=0 and flush_en pulse at cycle 21. flush_done at cycle 24 -> IDLE, busy=0 at cycle 26.
- Starvation: both requests held continuously, STARVE_LIMIT=4 -> grant order AXI,AXI,AXI,AXI,CSR,AXI… csr_trigger=1 only during the 5th transfer. starve_cnt=0 after the CSR grant.
- Abort: dqs_timeout during an AXI XFER -> flush issued next cycle and arb_err stays 0. Same-cycle dqs_timeout+rd_done -> exactly one flush_en pulse.
- Illegal instruction: mem_illegal_instrn_err=1 in IDLE with both requests high -> no ack. Asserted in XFER -> FLUSH next cycle.
- Watchdog: WDOG_W=4, CSR granted, no csr_read_end -> after 15 XFER cycles arb_err pulses once and flush_en pulses. Withholding flush_done another 15 cycles -> second arb_err and return to IDLE.
- Reset: reset_n=0 for 1 cycle in XFER -> next cycle all outputs 0, IDLE. A pending request is granted 1 cycle after reset_n=1.

Source files
------------

// File: rtl/rx_rd_req_arbiter.sv
// Receive-path read arbiter.
// Grants the shared read engine to either the AXI read requester or the CSR
// status-read requester. It holds start_read for the whole transfer and ends
// the transfer on completion, abort or watchdog expiry. A DQ FIFO flush must
// finish before the next grant is made.
// Ack handshake: a request is a level that the requester holds. The arbiter
// answers with a one-cycle ack pulse. The requester drops its request within
// one cycle of that ack. No second grant can occur before the flush completes.
module rx_rd_req_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_CNT_W = 3,
    parameter int WDOG_W       = 10
) (
    input  logic mem_clk,
    input  logic reset_n,
    input  logic axi_rd_req,
    output logic axi_rd_ack,
    input  logic csr_rd_req,
    output logic csr_rd_ack,
    output logic start_read,
    output logic axi_trigger,
    output logic csr_trigger,
    input  logic rd_done,
    input  logic csr_read_end,
    input  logic dqs_timeout,
    input  logic mem_illegal_instrn_err,
    output logic rcv_dq_fifo_flush_en,
    input  logic rcv_dq_fifo_flush_done,
    output logic busy,
    output logic arb_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] STARVE_SAT = '1;
    localparam logic [WDOG_W-1:0]       WDOG_MAX   = '1;

    state_t                  state;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [WDOG_W-1:0]       wdog;

    logic grant_ok;
    logic csr_wins;
    logic owner_end;
    logic abort_evt;
    logic wdog_exp;

    // A grant is only possible from IDLE with no illegal instruction flagged.
    // CSR takes the slot when AXI is absent or has starved CSR long enough.
    assign grant_ok  = (state == ST_IDLE) && !mem_illegal_instrn_err
                       && (axi_rd_req || csr_rd_req);
    assign csr_wins  = csr_rd_req && (!axi_rd_req || (starve_cnt == STARVE_LIM));
    // Only the current owner's end event terminates the transfer.
    assign owner_end = axi_trigger ? rd_done : csr_read_end;
    assign abort_evt = dqs_timeout || mem_illegal_instrn_err;
    assign wdog_exp  = (wdog == WDOG_MAX);

    // Count AXI grants made while CSR is waiting; any idle CSR cycle forgives.
    always_ff @(posedge mem_clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!csr_rd_req) begin
            starve_cnt <= '0;
        end else if (grant_ok && csr_wins) begin
            starve_cnt <= '0;
        end else if (grant_ok && (starve_cnt != STARVE_SAT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Grant / transfer / flush sequencer with registered outputs.
    always_ff @(posedge mem_clk) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            wdog                 <= '0;
            axi_rd_ack           <= 1'b0;
            csr_rd_ack           <= 1'b0;
            start_read           <= 1'b0;
            axi_trigger          <= 1'b0;
            csr_trigger          <= 1'b0;
            rcv_dq_fifo_flush_en <= 1'b0;
            busy                 <= 1'b0;
            arb_err              <= 1'b0;
        end else begin
            // Pulse outputs default low.
            axi_rd_ack           <= 1'b0;
            csr_rd_ack           <= 1'b0;
            rcv_dq_fifo_flush_en <= 1'b0;
            arb_err              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // busy lingers one cycle after IDLE re-entry, then follows grants.
                    busy <= grant_ok;
                    if (grant_ok) begin
                        state       <= ST_XFER;
                        wdog        <= '0;
                        start_read  <= 1'b1;
                        axi_rd_ack  <= !csr_wins;
                        csr_rd_ack  <= csr_wins;
                        axi_trigger <= !csr_wins;
                        csr_trigger <= csr_wins;
                    end
                end
                ST_XFER: begin
                    if (owner_end || abort_evt || wdog_exp) begin
                        state                <= ST_FLUSH;
                        wdog                 <= '0;
                        start_read           <= 1'b0;
                        axi_trigger          <= 1'b0;
                        csr_trigger          <= 1'b0;
                        rcv_dq_fifo_flush_en <= 1'b1;
                        // Watchdog is only reported when nothing else ended the transfer.
                        arb_err              <= wdog_exp && !owner_end && !abort_evt;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (rcv_dq_fifo_flush_done) begin
                        state <= ST_IDLE;
                    end else if (wdog_exp) begin
                        state   <= ST_IDLE;
                        arb_err <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    start_read  <= 1'b0;
                    axi_trigger <= 1'b0;
                    csr_trigger <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_rd_req_arbiter.sv
// Directed bench for rx_rd_req_arbiter. WDOG_W=5 gives a 31-cycle watchdog.
// Output vector order: {axi_ack, csr_ack, start, axi_trig, csr_trig,
// flush_en, busy, arb_err}.
module tb_rx_rd_req_arbiter;

    localparam logic [7:0] V_ZERO  = 8'b0000_0000;
    localparam logic [7:0] V_A_ACK = 8'b1011_0010;
    localparam logic [7:0] V_A_X   = 8'b0011_0010;
    localparam logic [7:0] V_C_ACK = 8'b0110_1010;
    localparam logic [7:0] V_C_X   = 8'b0010_1010;
    localparam logic [7:0] V_FLUSH = 8'b0000_0110;
    localparam logic [7:0] V_BUSY  = 8'b0000_0010;
    localparam logic [7:0] V_WD_X  = 8'b0000_0111;
    localparam logic [7:0] V_WD_F  = 8'b0000_0011;

    logic mem_clk = 1'b0;
    logic reset_n = 1'b0;
    logic axi_rd_req = 1'b0, csr_rd_req = 1'b0;
    logic axi_rd_ack, csr_rd_ack, start_read, axi_trigger, csr_trigger;
    logic rd_done = 1'b0, csr_read_end = 1'b0, dqs_timeout = 1'b0;
    logic mem_illegal_instrn_err = 1'b0;
    logic rcv_dq_fifo_flush_en, rcv_dq_fifo_flush_done = 1'b0;
    logic busy, arb_err;

    int n_cmp = 0;
    int n_bad = 0;

    rx_rd_req_arbiter #(.STARVE_LIMIT(4), .STARVE_CNT_W(3), .WDOG_W(5)) dut (
        .mem_clk(mem_clk), .reset_n(reset_n),
        .axi_rd_req(axi_rd_req), .axi_rd_ack(axi_rd_ack),
        .csr_rd_req(csr_rd_req), .csr_rd_ack(csr_rd_ack),
        .start_read(start_read), .axi_trigger(axi_trigger), .csr_trigger(csr_trigger),
        .rd_done(rd_done), .csr_read_end(csr_read_end), .dqs_timeout(dqs_timeout),
        .mem_illegal_instrn_err(mem_illegal_instrn_err),
        .rcv_dq_fifo_flush_en(rcv_dq_fifo_flush_en),
        .rcv_dq_fifo_flush_done(rcv_dq_fifo_flush_done),
        .busy(busy), .arb_err(arb_err)
    );

    // Clock and reset
    always #5 mem_clk = ~mem_clk;

    function automatic logic [7:0] outs();
        return {axi_rd_ack, csr_rd_ack, start_read, axi_trigger, csr_trigger,
                rcv_dq_fifo_flush_en, busy, arb_err};
    endfunction

    // Scoreboard check
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks: advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic run_expect(input string tag, input int n, input logic [7:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq(tag, 32'(outs()), 32'(exp));
        end
    endtask

    task automatic wait_ack(output logic [7:0] got);
        int k;
        k = 0;
        got = '0;
        while (k < 10) begin
            tick();
            k++;
            if (axi_rd_ack || csr_rd_ack) begin
                got = outs();
                break;
            end
        end
        if (!(axi_rd_ack || csr_rd_ack)) check_eq("ack_timeout", 32'd0, 32'd1);
    endtask

    // Finish a flush with done in the first flush cycle, then settle to idle.
    task automatic flush_to_idle(input string tag);
        rcv_dq_fifo_flush_done = 1'b1;
        run_expect({tag, "_idle_busy"}, 1, V_BUSY);
        rcv_dq_fifo_flush_done = 1'b0;
        run_expect({tag, "_idle"}, 1, V_ZERO);
    endtask

    logic [7:0] got_v;
    logic [7:0] exp_order [6];
    int flush_cnt;

    initial begin
        exp_order[0] = V_A_ACK; exp_order[1] = V_A_ACK; exp_order[2] = V_A_ACK;
        exp_order[3] = V_A_ACK; exp_order[4] = V_C_ACK; exp_order[5] = V_A_ACK;

        // Reset state
        tick(); tick();
        check_eq("reset_outs", 32'(outs()), 32'(V_ZERO));
        reset_n = 1'b1;
        run_expect("post_reset_idle", 2, V_ZERO);

        // AXI only: ack at 1, rd_done at 20, flush_en at 21, flush_done at 24, busy low at 26
        axi_rd_req = 1'b1;
        run_expect("axi_ack", 1, V_A_ACK);
        axi_rd_req = 1'b0;
        run_expect("axi_xfer", 19, V_A_X);
        rd_done = 1'b1;
        run_expect("axi_flush_en", 1, V_FLUSH);
        rd_done = 1'b0;
        run_expect("axi_flush_wait", 3, V_BUSY);
        rcv_dq_fifo_flush_done = 1'b1;
        run_expect("axi_idle_busy", 1, V_BUSY);
        rcv_dq_fifo_flush_done = 1'b0;
        run_expect("axi_busy_drop", 1, V_ZERO);

        // Starvation: both requests held, expect A,A,A,A,C,A
        axi_rd_req = 1'b1;
        csr_rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ack(got_v);
            check_eq($sformatf("starve_grant%0d", i), 32'(got_v), 32'(exp_order[i]));
            if (i == 5) begin
                axi_rd_req = 1'b0;
                csr_rd_req = 1'b0;
            end
            if (got_v[6]) csr_read_end = 1'b1;
            else rd_done = 1'b1;
            run_expect("starve_flush", 1, V_FLUSH);
            rd_done = 1'b0;
            csr_read_end = 1'b0;
            rcv_dq_fifo_flush_done = 1'b1;
            run_expect("starve_idle", 1, V_BUSY);
            rcv_dq_fifo_flush_done = 1'b0;
        end
        run_expect("starve_end_idle", 1, V_ZERO);

        // Abort by DQS timeout; non-owner end and stray flush_done ignored
        axi_rd_req = 1'b1;
        run_expect("abort_ack", 1, V_A_ACK);
        axi_rd_req = 1'b0;
        csr_read_end = 1'b1;
        rcv_dq_fifo_flush_done = 1'b1;
        run_expect("ignore_nonowner", 1, V_A_X);
        csr_read_end = 1'b0;
        rcv_dq_fifo_flush_done = 1'b0;
        run_expect("abort_xfer", 1, V_A_X);
        dqs_timeout = 1'b1;
        run_expect("dqs_flush_no_err", 1, V_FLUSH);
        dqs_timeout = 1'b0;
        flush_to_idle("dqs");

        // Same-cycle dqs_timeout and rd_done: exactly one flush_en pulse
        axi_rd_req = 1'b1;
        run_expect("dual_ack", 1, V_A_ACK);
        axi_rd_req = 1'b0;
        dqs_timeout = 1'b1;
        rd_done = 1'b1;
        run_expect("dual_flush", 1, V_FLUSH);
        dqs_timeout = 1'b0;
        rd_done = 1'b0;
        flush_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rcv_dq_fifo_flush_en) flush_cnt++;
        end
        check_eq("dual_flush_count", 32'(flush_cnt), 32'd1);
        flush_to_idle("dual");

        // Illegal instruction blocks grants in IDLE, aborts in XFER
        mem_illegal_instrn_err = 1'b1;
        axi_rd_req = 1'b1;
        csr_rd_req = 1'b1;
        run_expect("illegal_no_ack", 5, V_ZERO);
        mem_illegal_instrn_err = 1'b0;
        run_expect("illegal_release_ack", 1, V_A_ACK);
        axi_rd_req = 1'b0;
        csr_rd_req = 1'b0;
        run_expect("illegal_xfer", 1, V_A_X);
        mem_illegal_instrn_err = 1'b1;
        run_expect("illegal_flush", 1, V_FLUSH);
        mem_illegal_instrn_err = 1'b0;
        flush_to_idle("illegal");

        // Watchdog: CSR transfer never ends, flush never completes
        csr_rd_req = 1'b1;
        run_expect("wd_ack", 1, V_C_ACK);
        csr_rd_req = 1'b0;
        run_expect("wd_xfer", 31, V_C_X);
        run_expect("wd_xfer_expire", 1, V_WD_X);
        run_expect("wd_flush_wait", 31, V_BUSY);
        run_expect("wd_flush_expire", 1, V_WD_F);
        run_expect("wd_idle", 1, V_ZERO);

        // Reset mid-transfer, then pending CSR request granted
        axi_rd_req = 1'b1;
        run_expect("rst_ack", 1, V_A_ACK);
        axi_rd_req = 1'b0;
        run_expect("rst_xfer", 1, V_A_X);
        reset_n = 1'b0;
        csr_rd_req = 1'b1;
        run_expect("rst_clears", 1, V_ZERO);
        reset_n = 1'b1;
        run_expect("rst_regrant", 1, V_C_ACK);
        csr_rd_req = 1'b0;
        csr_read_end = 1'b1;
        run_expect("rst_flush", 1, V_FLUSH);
        csr_read_end = 1'b0;
        flush_to_idle("rst");

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
